mio_responder: RTL and testbench

- Memory/IO responder at the far end of the multi-cycle CPU's memory bus.
- Accepts word read/write requests and decodes the address to one of:
  - an internal word RAM,
  - a LED output register,
  - a read-only switch port,
  - a free-running cycle counter.
- Returns read data on data2CPU and signals completion with a one-cycle MIO_ready pulse after a programmable number of wait states.

---
 rtl/mio_responder_if.sv | 20 ++
 rtl/mio_responder.sv | 140 ++++++++++++++
 tb/tb_mio_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mio_responder_if.sv
// Memory bus between the multi-cycle CPU and the memory/IO responder.
//   mem_req   : request strobe, held by the CPU until MIO_ready is seen
//   mem_w     : 1 = write, 0 = read
//   M_addr    : byte address (bits [1:0] ignored by the responder)
//   data_out  : CPU write data
//   data2CPU  : read data returned to the CPU
//   MIO_ready : one-cycle completion pulse
interface mio_responder_if;
  logic        mem_req;
  logic        mem_w;
  logic [31:0] M_addr;
  logic [31:0] data_out;
  logic [31:0] data2CPU;
  logic        MIO_ready;

  modport master (output mem_req, mem_w, M_addr, data_out,
                  input  data2CPU, MIO_ready);
  modport slave  (input  mem_req, mem_w, M_addr, data_out,
                  output data2CPU, MIO_ready);
endinterface

// File: rtl/mio_responder.sv
// Memory/IO responder at the far end of the CPU memory bus.
// Decodes each word request to an internal RAM, a LED register, a read-only
// switch port or a free-running cycle counter, and completes it with a
// one-cycle MIO_ready pulse after WAIT_STATES extra cycles.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous, active-low reset
//   bus     : CPU bus (slave side)
//   sw_in   : switch inputs (read at 0xF0000004)
//   led_out : LED register (R/W at 0xF0000000)
//   bus_err : sticky flag, set when an unmapped address is accessed
module mio_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2,
  parameter int LED_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  mio_responder_if.slave   bus,
  input  logic [LED_W-1:0] sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             bus_err
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [3:0]        wcnt_q;
  logic [31:2]       addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       cnt_q;
  logic [31:0]       ram_rd_q;
  logic              rdy_q;
  logic [LED_W-1:0]  led_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  // Byte-lane bits of the address carry no information for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.M_addr[1:0];

  // Address decode works on the latched address, which is stable from WAIT on.
  logic sel_ram, sel_led, sel_sw, sel_cnt, unmapped;
  assign sel_ram  = (addr_q[31:28] == 4'h0) && (addr_q[27:ADDR_W+2] == '0);
  assign sel_led  = (addr_q == 30'h3C00_0000);
  assign sel_sw   = (addr_q == 30'h3C00_0001);
  assign sel_cnt  = (addr_q == 30'h3C00_0002);
  assign unmapped = !(sel_ram || sel_led || sel_sw || sel_cnt);

  logic start, enter_resp, commit;
  assign start      = (state_q == IDLE) && bus.mem_req;
  assign enter_resp = (start && (WS == 4'd0)) ||
                      ((state_q == WAIT) && (wcnt_q == 4'd1));
  assign commit     = (state_q == RESP) && we_q;

  // With zero wait states the RAM read is issued in the same edge that
  // captures the request, so the index must come straight from the bus.
  logic [ADDR_W-1:0] rd_idx;
  assign rd_idx = (state_q == IDLE) ? bus.M_addr[ADDR_W+1:2]
                                    : addr_q[ADDR_W+1:2];

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (sel_ram)      rd_mux = ram_rd_q;
    else if (sel_led) rd_mux = 32'(led_q);
    else if (sel_sw)  rd_mux = 32'(sw_in);
    else if (sel_cnt) rd_mux = cnt_q;
  end

  // Read data is live from the decoded source during RESP and then held in
  // rdata_q; writes never disturb the held value.
  assign bus.data2CPU  = ((state_q == RESP) && !we_q) ? rd_mux : rdata_q;
  assign bus.MIO_ready = rdy_q;
  assign led_out       = led_q;
  assign bus_err       = err_q;

  // RAM contents survive reset; a reset in RESP still suppresses the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (enter_resp) ram_rd_q <= mem[rd_idx];
      if (commit && sel_ram) mem[addr_q[ADDR_W+1:2]] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      // A committed counter write takes priority over the increment.
      cnt_q <= (commit && sel_cnt) ? wdata_q : cnt_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (bus.mem_req) begin
            addr_q  <= bus.M_addr[31:2];
            we_q    <= bus.mem_w;
            wdata_q <= bus.data_out;
            wcnt_q  <= WS;
            if (WS == 4'd0) begin
              state_q <= RESP;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_q <= RESP;
            rdy_q   <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          if (!we_q)            rdata_q <= rd_mux;
          if (we_q && sel_led)  led_q   <= wdata_q[LED_W-1:0];
          if (unmapped)         err_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: one instance with two wait states
// (dut_a) and one with zero wait states (dut_b). Drivers push expected
// responses (ready cycle and read data) into per-instance queues; monitors
// pop and compare on every MIO_ready pulse.
module tb_mio_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_a, led_b;
  logic        err_a, err_b;

  always #5 clk = ~clk;

  mio_responder_if ifa ();
  mio_responder_if ifb ();

  mio_responder #(.ADDR_W(10), .WAIT_STATES(2), .LED_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave),
    .sw_in(sw_in), .led_out(led_a), .bus_err(err_a));

  mio_responder #(.ADDR_W(10), .WAIT_STATES(0), .LED_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave),
    .sw_in(sw_in), .led_out(led_b), .bus_err(err_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifa.MIO_ready === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_ready: got pulse at cycle %0d want none", cyc);
      end else begin
        e = qa.pop_front();
        check("a_ready_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) check("a_rdata", ifa.data2CPU, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ifb.MIO_ready === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_ready: got pulse at cycle %0d want none", cyc);
      end else begin
        e = qb.pop_front();
        check("b_ready_cycle", 32'(cyc), 32'(e.cyc));
        if (e.rd) check("b_rdata", ifb.data2CPU, e.data);
      end
    end
  end

  function automatic logic rdy(input bit b);
    return b ? ifb.MIO_ready : ifa.MIO_ready;
  endfunction

  task automatic set_bus(input bit b, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (b) begin
      ifb.mem_req = req; ifb.mem_w = we; ifb.M_addr = addr; ifb.data_out = wd;
    end else begin
      ifa.mem_req = req; ifa.mem_w = we; ifa.M_addr = addr; ifa.data_out = wd;
    end
  endtask

  // Issue at a falling edge; the request is sampled at the next rising edge
  // and the pulse is expected 1+WS cycles after that. Returns at the falling
  // edge of the RESP cycle; keep leaves mem_req high for a back-to-back issue.
  task automatic txn(input bit b, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp, input bit keep);
    int   ws = b ? 0 : 2;
    int   n  = 0;
    exp_t e;
    @(negedge clk);
    set_bus(b, 1'b1, we, addr, wd);
    e.rd = !we; e.data = exp; e.cyc = cyc + 1 + ws;
    if (b) qb.push_back(e); else qa.push_back(e);
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(b) && n < 20);
    if (!rdy(b)) begin
      total++; bad++;
      $display("FAIL ready_timeout: got no MIO_ready want pulse (addr %h)", addr);
    end
    if (!keep) set_bus(b, 1'b0, 1'b0, addr, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_bus(1'b0, 1'b0, 1'b0, '0, '0);
    set_bus(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(ifa.MIO_ready), 32'd0);
    check("rst_d2c_a",   ifa.data2CPU,       32'd0);
    check("rst_led_a",   32'(led_a),         32'd0);
    check("rst_err_a",   32'(err_a),         32'd0);
    check("rst_d2c_b",   ifb.data2CPU,       32'd0);
    reset = 1'b1;

    // RAM write then read, two wait states
    txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, '0, 0);
    txn(0, 0, 32'h0000_0010, '0, 32'hDEAD_BEEF, 0);
    repeat (3) @(negedge clk);
    check("a_d2c_hold", ifa.data2CPU, 32'hDEAD_BEEF);

    // Zero wait states: preload, then three reads with mem_req held
    txn(1, 1, 32'h0000_0000, 32'd1, '0, 0);
    txn(1, 1, 32'h0000_0004, 32'd2, '0, 0);
    txn(1, 1, 32'h0000_0008, 32'd3, '0, 0);
    txn(1, 1, 32'h0000_0FFC, 32'hCAFE_F00D, '0, 0);
    txn(1, 0, 32'h0000_0000, '0, 32'd1, 1);
    txn(1, 0, 32'h0000_0004, '0, 32'd2, 1);
    txn(1, 0, 32'h0000_0008, '0, 32'd3, 0);
    txn(1, 0, 32'h0000_0FFC, '0, 32'hCAFE_F00D, 0);
    // Just above the RAM window: unmapped, must not alias onto word 0
    txn(1, 1, 32'h0000_1000, 32'h55, '0, 0);
    txn(1, 0, 32'h0000_0000, '0, 32'd1, 0);
    check("b_err_alias", 32'(err_b), 32'd1);

    // LED register
    txn(0, 1, 32'hF000_0000, 32'h0000_A5A5, '0, 0);
    check("led_before_commit", 32'(led_a), 32'd0);
    @(negedge clk);
    check("led_after_resp", 32'(led_a), 32'h0000_A5A5);
    txn(0, 0, 32'hF000_0000, '0, 32'h0000_A5A5, 0);

    // Switch port, read-only
    sw_in = 16'h1234;
    txn(0, 0, 32'hF000_0004, '0, 32'h0000_1234, 0);
    txn(0, 1, 32'hF000_0004, 32'h0000_FFFF, '0, 0);
    @(negedge clk);
    check("sw_write_led", 32'(led_a), 32'h0000_A5A5);
    check("sw_write_err", 32'(err_a), 32'd0);
    check("a_d2c_after_write", ifa.data2CPU, 32'h0000_1234);

    // Counter: FFFFFFFE loaded at the end of RESP; the read is sampled one
    // cycle later and its RESP comes three edges after the load -> 1.
    txn(0, 1, 32'hF000_0008, 32'hFFFF_FFFE, '0, 0);
    txn(0, 0, 32'hF000_0008, '0, 32'h0000_0001, 0);

    // Unmapped read, then reset in the middle of a write's WAIT
    txn(0, 0, 32'h8000_0000, '0, 32'd0, 0);
    @(negedge clk);
    check("err_set", 32'(err_a), 32'd1);
    set_bus(0, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111);
    @(negedge clk);
    reset = 1'b0;
    set_bus(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    check("err_cleared", 32'(err_a), 32'd0);
    check("d2c_cleared", ifa.data2CPU, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_ready", 32'(ifa.MIO_ready), 32'd0);
    end
    txn(0, 0, 32'h0000_0010, '0, 32'hDEAD_BEEF, 0);

    repeat (4) @(negedge clk);
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
